// File: rtl/dff_pipe.sv
// DEPTH-stage, WIDTH-bit register pipeline with per-stage valid bits, valid/ready
// backpressure, bubble collapse, synchronous flush and a registered occupancy count.
module dff_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int               OCC_W   = $clog2(DEPTH+1);
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

    logic [DEPTH-1:0]             vld_q, vld_d;
    logic [DEPTH-1:0][WIDTH-1:0]  data_q, data_d;
    logic [OCC_W-1:0]             occ_q, occ_d;
    logic [DEPTH-1:0]             adv;
    logic [DEPTH-1:0]             src_vld;
    logic [DEPTH-1:0][WIDTH-1:0]  src_data;
    logic                         in_xfer, out_xfer;

    // Advance chain, walked from the output end; a running bit avoids a
    // vector that depends on its own neighbouring bits.
    always_comb begin
        logic go;
        adv = '0;
        go  = !vld_q[DEPTH-1] || out_ready;
        adv[DEPTH-1] = go;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            go     = !vld_q[i] || (vld_q[i+1] ? go : 1'b1);
            adv[i] = go;
        end
    end

    always_comb begin
        src_vld     = '0;
        src_data    = '0;
        src_vld[0]  = in_valid;
        src_data[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_vld[i]  = vld_q[i-1];
            src_data[i] = data_q[i-1];
        end
    end

    assign in_ready  = adv[0] && !flush;
    assign in_xfer   = in_valid && in_ready;
    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign out_xfer  = out_valid && out_ready;
    assign occupancy = occ_q;

    // Data only loads behind a valid item; flush drops valids but keeps data.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
                vld_d[i] = 1'b0;
            end else if (adv[i]) begin
                vld_d[i] = src_vld[i];
                if (src_vld[i]) begin
                    data_d[i] = src_data[i];
                end
            end
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (in_xfer && !out_xfer) begin
            occ_d = occ_q + OCC_ONE;
        end else if (!in_xfer && out_xfer) begin
            occ_d = occ_q - OCC_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            data_q <= {DEPTH{RESET_VAL}};
            occ_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            occ_q  <= occ_d;
        end
    end

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: a DEPTH=4 instance checked against a slot-list model that
// compacts items toward the output, plus a DEPTH=1 instance for the corner case.
module tb_dff_pipe;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n, flush, in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid;
    logic [7:0] out_data;
    logic [2:0] occupancy;

    logic       s_flush, s_in_valid, s_out_ready;
    logic [7:0] s_in_data;
    logic       s_in_ready, s_out_valid;
    logic [7:0] s_out_data;
    logic [0:0] s_occ;

    int n_vec = 0;
    int n_err = 0;

    dff_pipe #(.WIDTH(8), .DEPTH(D), .RESET_VAL(8'h00)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .occupancy(s_occ)
    );

    always #5 clk = ~clk;

    // Reference: slot D-1 is the output. Each edge pops the output if taken,
    // then every item slides into a free slot ahead of it (one step per edge),
    // then a new item enters slot 0 if it is free.
    bit         m_v[D];
    logic [7:0] m_d[D];

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < D; i++) n += int'(m_v[i]);
        return n;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < D; i++) begin
                m_v[i] = 1'b0;
                m_d[i] = 8'h00;
            end
        end else if (flush) begin
            for (int i = 0; i < D; i++) m_v[i] = 1'b0;
        end else begin
            if (m_v[D-1] && out_ready) m_v[D-1] = 1'b0;
            for (int i = D - 1; i > 0; i--) begin
                if (!m_v[i] && m_v[i-1]) begin
                    m_v[i]   = 1'b1;
                    m_d[i]   = m_d[i-1];
                    m_v[i-1] = 1'b0;
                end
            end
            if (!m_v[0] && in_valid) begin
                m_v[0] = 1'b1;
                m_d[0] = in_data;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %0h want 00", out_data); end
        n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        n_vec++; if (s_occ !== 1'b0) begin n_err++; $display("FAIL reset_d1_occ: got %0d want 0", s_occ); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic exp_v;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_valid = (c < 16);
            in_data  = (c < 16) ? 8'(c + 1) : 8'($urandom);
            cyc();
            exp_v = (c >= 3 && c <= 18);
            n_vec++; if (out_valid !== exp_v) begin n_err++; $display("FAIL stream_valid c=%0d: got %0b want %0b", c, out_valid, exp_v); end
            if (exp_v) begin
                n_vec++; if (out_data !== 8'(c - 2)) begin n_err++; $display("FAIL stream_data c=%0d: got %0h want %0h", c, out_data, 8'(c - 2)); end
            end
            n_vec++; if (occupancy !== 3'(m_count())) begin n_err++; $display("FAIL stream_occ c=%0d: got %0d want %0d", c, occupancy, m_count()); end
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready c=%0d: got %0b want 1", c, in_ready); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] sent[4];
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sent[k]  = 8'($urandom);
            in_valid = 1'b1;
            in_data  = sent[k];
            cyc();
        end
        in_data = 8'($urandom);
        #1;
        n_vec++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL bp_full_occ: got %0d want 4", occupancy); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %0b want 0", in_ready); end
        n_vec++; if (out_data !== sent[0]) begin n_err++; $display("FAIL bp_head: got %0h want %0h", out_data, sent[0]); end
        cyc();
        n_vec++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL bp_hold_occ: got %0d want 4", occupancy); end
        n_vec++; if (out_data !== sent[0]) begin n_err++; $display("FAIL bp_hold_head: got %0h want %0h", out_data, sent[0]); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (out_valid !== 1'b1 || out_data !== sent[k]) begin
                n_err++; $display("FAIL bp_drain k=%0d: got v=%0b d=%0h want v=1 d=%0h", k, out_valid, out_data, sent[k]);
            end
            cyc();
        end
        n_vec++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_empty: got occ=%0d v=%0b want occ=0 v=0", occupancy, out_valid);
        end
    endtask

    task automatic test_bubble();
        logic [7:0] a, b;
        a = 8'($urandom);
        b = 8'($urandom);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = a; cyc();
        in_valid = 1'b0; cyc(); cyc();
        in_valid = 1'b1; in_data = b; cyc();
        in_valid = 1'b0;
        repeat (4) cyc();
        n_vec++; if (occupancy !== 3'd2) begin n_err++; $display("FAIL bubble_occ: got %0d want 2", occupancy); end
        n_vec++; if (out_valid !== 1'b1 || out_data !== a) begin n_err++; $display("FAIL bubble_head: got v=%0b d=%0h want v=1 d=%0h", out_valid, out_data, a); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bubble_ready: got %0b want 1", in_ready); end
        out_ready = 1'b1; cyc(); out_ready = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || out_data !== b) begin n_err++; $display("FAIL bubble_behind: got v=%0b d=%0h want v=1 d=%0h", out_valid, out_data, b); end
        n_vec++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL bubble_occ1: got %0d want 1", occupancy); end
        out_ready = 1'b1; cyc(); out_ready = 1'b0;
        n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL bubble_drain: got %0d want 0", occupancy); end
    endtask

    task automatic test_flush();
        logic [7:0] it[3];
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            it[k] = 8'($urandom);
            in_valid = 1'b1; in_data = it[k];
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        n_vec++; if (occupancy !== 3'd3) begin n_err++; $display("FAIL flush_pre_occ: got %0d want 3", occupancy); end
        flush = 1'b1; in_valid = 1'b1; in_data = 8'($urandom); out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %0b want 0", in_ready); end
        n_vec++; if (out_valid !== 1'b1 || out_data !== it[0]) begin n_err++; $display("FAIL flush_cur_out: got v=%0b d=%0h want v=1 d=%0h", out_valid, out_data, it[0]); end
        cyc();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
        n_vec++; if (out_data !== it[0]) begin n_err++; $display("FAIL flush_data_held: got %0h want %0h", out_data, it[0]); end
        cyc();
        n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL flush_no_accept: got %0d want 0", occupancy); end
    endtask

    task automatic test_random();
        logic exp_rdy;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = (c < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            #1;
            exp_rdy = !flush && (m_count() < D || out_ready);
            n_vec++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL rand_ready c=%0d: got %0b want %0b", c, in_ready, exp_rdy); end
            cyc();
            n_vec++; if (out_valid !== m_v[D-1]) begin n_err++; $display("FAIL rand_valid c=%0d: got %0b want %0b", c, out_valid, m_v[D-1]); end
            n_vec++; if (out_data !== m_d[D-1]) begin n_err++; $display("FAIL rand_data c=%0d: got %0h want %0h", c, out_data, m_d[D-1]); end
            n_vec++; if (occupancy !== 3'(m_count())) begin n_err++; $display("FAIL rand_occ c=%0d: got %0d want %0d", c, occupancy, m_count()); end
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_midreset();
        logic [7:0] x;
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (6) begin in_data = 8'($urandom); cyc(); end
        n_vec++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL mr_full: got %0d want 4", occupancy); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mr_valid: got %0b want 0", out_valid); end
        n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL mr_occ: got %0d want 0", occupancy); end
        n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL mr_data: got %0h want 00", out_data); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mr_ready: got %0b want 1", in_ready); end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        x = 8'($urandom);
        in_valid = 1'b1; in_data = x;
        cyc();
        in_valid = 1'b0;
        n_vec++; if (occupancy !== 3'd1 || out_valid !== 1'b0) begin n_err++; $display("FAIL mr_first: got occ=%0d v=%0b want occ=1 v=0", occupancy, out_valid); end
        repeat (3) cyc();
        n_vec++; if (out_valid !== 1'b1 || out_data !== x) begin n_err++; $display("FAIL mr_latency: got v=%0b d=%0h want v=1 d=%0h", out_valid, out_data, x); end
    endtask

    task automatic test_depth1();
        logic [7:0] dk;
        s_in_valid = 1'b1; s_out_ready = 1'b1;
        #1;
        n_vec++; if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL d1_ready0: got %0b want 1", s_in_ready); end
        for (int k = 0; k < 10; k++) begin
            dk = 8'($urandom);
            s_in_data = dk;
            cyc();
            n_vec++; if (s_out_valid !== 1'b1 || s_out_data !== dk) begin n_err++; $display("FAIL d1_data k=%0d: got v=%0b d=%0h want v=1 d=%0h", k, s_out_valid, s_out_data, dk); end
            n_vec++; if (s_occ !== 1'b1) begin n_err++; $display("FAIL d1_occ k=%0d: got %0d want 1", k, s_occ); end
            n_vec++; if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL d1_ready k=%0d: got %0b want 1", k, s_in_ready); end
        end
        s_in_valid = 1'b0;
        cyc();
        n_vec++; if (s_out_valid !== 1'b0 || s_occ !== 1'b0) begin n_err++; $display("FAIL d1_empty: got v=%0b occ=%0d want v=0 occ=0", s_out_valid, s_occ); end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = 8'h00; s_out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_flush();
        test_random();
        test_midreset();
        test_depth1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
